// File: rtl/gt_sched.sv
// Round-robin sharing of the global-time latch between NREQ trigger requesters.
// Each rising trigger freezes {gtin, phase} privately; a one-slot stage drains them.
module gt_sched #(
  parameter int NREQ = 4,
  parameter int SRCW = 2
) (
  input  logic              adcclk,
  input  logic              reset,
  input  logic [21:0]       gtin,
  input  logic [2:0]        phase,
  input  logic [NREQ-1:0]   trig,
  output logic [24:0]       ts_data,
  output logic [SRCW-1:0]   ts_src,
  output logic              ts_valid,
  input  logic              ts_ready,
  output logic [NREQ-1:0]   busy,
  output logic [15:0]       lost,
  input  logic              lost_clr
);

  localparam logic [15:0] LOST_MAX = 16'hFFFF;

  logic [NREQ-1:0] trig_d_q;
  logic [NREQ-1:0] busy_q, busy_d;
  logic [24:0]     hold_q [NREQ];
  logic [24:0]     hold_d [NREQ];
  logic [24:0]     ts_data_q, ts_data_d;
  logic [SRCW-1:0] ts_src_q, ts_src_d;
  logic            ts_valid_q, ts_valid_d;
  logic [SRCW-1:0] ptr_q, ptr_d;
  logic [15:0]     lost_q, lost_d;

  logic [NREQ-1:0] trig_rise, cap, lost_edge;
  logic            slot_free, found, grant_vld;
  logic [SRCW-1:0] grant_idx;
  logic [4:0]      n_lost;
  logic [16:0]     lost_sum;

  function automatic logic [SRCW-1:0] wrap_idx(input int a);
    return (a >= NREQ) ? SRCW'(a - NREQ) : SRCW'(a);
  endfunction

  assign trig_rise = trig & ~trig_d_q;
  assign slot_free = ~ts_valid_q | ts_ready;
  assign grant_vld = found & slot_free;

  // First busy hold at or above ptr, wrapping around.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && busy_q[wrap_idx(int'(ptr_q) + k)]) begin
        found     = 1'b1;
        grant_idx = wrap_idx(int'(ptr_q) + k);
      end
    end
  end

  // A hold being granted this cycle may be refilled by an edge in the same cycle.
  always_comb begin
    busy_d = busy_q;
    hold_d = hold_q;
    cap    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cap[i] = trig_rise[i] & (~busy_q[i] | (grant_vld && grant_idx == SRCW'(i)));
      if (cap[i]) begin
        busy_d[i] = 1'b1;
        hold_d[i] = {gtin, phase};
      end else if (grant_vld && grant_idx == SRCW'(i)) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  assign lost_edge = trig_rise & ~cap;

  always_comb begin
    n_lost = '0;
    for (int i = 0; i < NREQ; i++) begin
      n_lost = n_lost + 5'(lost_edge[i]);
    end
    lost_sum = {1'b0, lost_q} + 17'(n_lost);
    if (lost_clr)          lost_d = '0;
    else if (lost_sum[16]) lost_d = LOST_MAX;
    else                   lost_d = lost_sum[15:0];
  end

  always_comb begin
    ts_data_d  = ts_data_q;
    ts_src_d   = ts_src_q;
    ts_valid_d = ts_valid_q;
    ptr_d      = ptr_q;
    if (grant_vld) begin
      ts_data_d  = hold_q[grant_idx];
      ts_src_d   = grant_idx;
      ts_valid_d = 1'b1;
      ptr_d      = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end else if (slot_free) begin
      ts_valid_d = 1'b0;
    end
  end

  // trig_d resets high so a trigger already asserted through reset is not an edge.
  always_ff @(posedge adcclk or posedge reset) begin
    if (reset) begin
      trig_d_q   <= '1;
      busy_q     <= '0;
      ts_data_q  <= '0;
      ts_src_q   <= '0;
      ts_valid_q <= 1'b0;
      ptr_q      <= '0;
      lost_q     <= '0;
      // NOTE: the holds are a handful of flops, not a RAM, so they take the async reset like the rest of the state.
      for (int i = 0; i < NREQ; i++) hold_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      trig_d_q   <= trig;
      busy_q     <= busy_d;
      ts_data_q  <= ts_data_d;
      ts_src_q   <= ts_src_d;
      ts_valid_q <= ts_valid_d;
      ptr_q      <= ptr_d;
      lost_q     <= lost_d;
      for (int i = 0; i < NREQ; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign ts_data  = ts_data_q;
  assign ts_src   = ts_src_q;
  assign ts_valid = ts_valid_q;
  assign busy     = busy_q;
  assign lost     = lost_q;

endmodule

// File: tb/tb_gt_sched.sv
// Scenario bench for gt_sched: per-feature tasks with inline checks, plus a
// scoreboard queue that is drained by an output monitor on every accepted beat.
module tb_gt_sched;

  localparam int NREQ = 4;
  localparam int SRCW = 2;

  logic            adcclk = 1'b0;
  logic            reset;
  logic [21:0]     gtin;
  logic [2:0]      phase;
  logic [NREQ-1:0] trig;
  logic [24:0]     ts_data;
  logic [SRCW-1:0] ts_src;
  logic            ts_valid;
  logic            ts_ready;
  logic [NREQ-1:0] busy;
  logic [15:0]     lost;
  logic            lost_clr;

  int total = 0;
  int bad   = 0;

  logic [SRCW+24:0] sb [$];
  logic [SRCW+24:0] exp_e;

  gt_sched #(.NREQ(NREQ), .SRCW(SRCW)) dut (
    .adcclk   (adcclk),
    .reset    (reset),
    .gtin     (gtin),
    .phase    (phase),
    .trig     (trig),
    .ts_data  (ts_data),
    .ts_src   (ts_src),
    .ts_valid (ts_valid),
    .ts_ready (ts_ready),
    .busy     (busy),
    .lost     (lost),
    .lost_clr (lost_clr)
  );

  always #5 adcclk = ~adcclk;

  // Inputs change 2 time units after a rising edge; checks in tasks happen there too.
  task automatic tick();
    @(posedge adcclk);
    #2;
  endtask

  // A beat is accepted at the next rising edge when valid & ready hold at the falling edge.
  always @(negedge adcclk) begin
    if (!reset && ts_valid && ts_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got src=%0d data=%h, expected no output", ts_src, ts_data);
      end else begin
        exp_e = sb.pop_front();
        if ({ts_src, ts_data} !== exp_e) begin
          bad++;
          $display("FAIL sb_beat: got src=%0d data=%h, expected src=%0d data=%h",
                   ts_src, ts_data, exp_e[SRCW+24:25], exp_e[24:0]);
        end
      end
    end
  end

  task automatic do_reset();
    trig     = '0;
    lost_clr = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    trig = '1; ts_ready = 1'b1; lost_clr = 1'b0; gtin = 22'd5; phase = 3'd0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (busy !== 4'b0000) begin bad++; $display("FAIL rst_hold_busy: got %b, expected 0000", busy); end
      total++;
      if (ts_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid: got %b, expected 0", ts_valid); end
    end
    total++;
    if (lost !== 16'd0) begin bad++; $display("FAIL rst_hold_lost: got %0d, expected 0", lost); end
    // Start a burst, then reset while the slot holds a beat.
    trig = '0; tick();
    trig = '1; gtin = 22'd77; tick();
    trig = '0; tick();
    total++;
    if (ts_valid !== 1'b1) begin bad++; $display("FAIL rst_burst_valid: got %b, expected 1", ts_valid); end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({ts_valid, ts_data, ts_src, busy, lost} !== '0) begin
      bad++;
      $display("FAIL rst_async: got valid=%b data=%h src=%0d busy=%b lost=%0d, expected all 0",
               ts_valid, ts_data, ts_src, busy, lost);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (ts_valid !== 1'b0 || busy !== 4'b0000) begin
        bad++; $display("FAIL rst_discard: got valid=%b busy=%b, expected 0 and 0000", ts_valid, busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    ts_ready = 1'b1;
    gtin = 22'h00ABCD; phase = 3'd5; trig = 4'b0100;
    sb.push_back({2'd2, 25'h0055E6D});
    tick();
    total++;
    if (busy !== 4'b0100 || ts_valid !== 1'b0) begin
      bad++; $display("FAIL single_capture: got busy=%b valid=%b, expected 0100 0", busy, ts_valid);
    end
    gtin = 22'h00ABCE; phase = 3'd6;
    tick();
    total++;
    if (ts_valid !== 1'b1 || ts_data !== 25'h0055E6D || ts_src !== 2'd2) begin
      bad++; $display("FAIL single_out: got valid=%b data=%h src=%0d, expected 1 0055e6d 2", ts_valid, ts_data, ts_src);
    end
    total++;
    if (busy !== 4'b0000) begin bad++; $display("FAIL single_busy_clr: got %b, expected 0000", busy); end
    trig = '0;
    tick();
    total++;
    if (ts_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got %b, expected 0", ts_valid); end
  endtask

  task automatic test_simultaneous();
    logic [24:0] d100, d200;
    do_reset();
    ts_ready = 1'b1;
    d100 = {22'd100, 3'd3};
    d200 = {22'd200, 3'd3};
    gtin = 22'd100; phase = 3'd3; trig = 4'b1111;
    for (int k = 0; k < NREQ; k++) sb.push_back({SRCW'(k), d100});
    tick();
    total++;
    if (busy !== 4'b1111) begin bad++; $display("FAIL simul_busy: got %b, expected 1111", busy); end
    gtin = 22'd101; trig = '0;
    for (int k = 0; k < NREQ; k++) begin
      tick();
      total++;
      if (ts_valid !== 1'b1 || ts_src !== SRCW'(k) || ts_data !== d100) begin
        bad++; $display("FAIL simul_beat%0d: got valid=%b src=%0d data=%h, expected 1 %0d %h",
                        k, ts_valid, ts_src, ts_data, k, d100);
      end
    end
    tick();
    total++;
    if (ts_valid !== 1'b0 || busy !== 4'b0000) begin
      bad++; $display("FAIL simul_drained: got valid=%b busy=%b, expected 0 0000", ts_valid, busy);
    end
    // With ptr back at 0, requester 0 beats requester 3.
    gtin = 22'd200; trig = 4'b1001;
    sb.push_back({2'd0, d200});
    sb.push_back({2'd3, d200});
    tick();
    gtin = 22'd201; trig = '0;
    tick();
    total++;
    if (ts_src !== 2'd0 || ts_valid !== 1'b1) begin bad++; $display("FAIL simul_ptr_first: got src=%0d valid=%b, expected 0 1", ts_src, ts_valid); end
    tick();
    total++;
    if (ts_src !== 2'd3 || ts_valid !== 1'b1) begin bad++; $display("FAIL simul_ptr_second: got src=%0d valid=%b, expected 3 1", ts_src, ts_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    ts_ready = 1'b0; phase = 3'd2;
    sb.push_back({2'd1, {22'd10, 3'd2}});
    sb.push_back({2'd1, {22'd20, 3'd2}});
    gtin = 22'd10; trig = 4'b0010;
    tick();
    total++;
    if (busy !== 4'b0010) begin bad++; $display("FAIL bp_first_busy: got %b, expected 0010", busy); end
    gtin = 22'd11; trig = '0;
    tick();
    total++;
    if (ts_valid !== 1'b1 || ts_data !== {22'd10, 3'd2} || busy !== 4'b0000) begin
      bad++; $display("FAIL bp_slot: got valid=%b data=%h busy=%b, expected 1 %h 0000", ts_valid, ts_data, busy, {22'd10, 3'd2});
    end
    gtin = 22'd20; trig = 4'b0010;
    tick();
    total++;
    if (busy !== 4'b0010 || lost !== 16'd0) begin
      bad++; $display("FAIL bp_second_held: got busy=%b lost=%0d, expected 0010 0", busy, lost);
    end
    gtin = 22'd21; trig = '0;
    tick();
    gtin = 22'd30; trig = 4'b0010;
    tick();
    total++;
    if (lost !== 16'd1) begin bad++; $display("FAIL bp_third_lost: got %0d, expected 1", lost); end
    total++;
    if (ts_data !== {22'd10, 3'd2} || ts_src !== 2'd1 || ts_valid !== 1'b1) begin
      bad++; $display("FAIL bp_stable: got valid=%b data=%h src=%0d, expected 1 %h 1", ts_valid, ts_data, ts_src, {22'd10, 3'd2});
    end
    trig = '0; ts_ready = 1'b1;
    tick();
    total++;
    if (ts_data !== {22'd20, 3'd2} || busy !== 4'b0000) begin
      bad++; $display("FAIL bp_release: got data=%h busy=%b, expected %h 0000", ts_data, busy, {22'd20, 3'd2});
    end
    tick();
    total++;
    if (ts_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b, expected 0", ts_valid); end
  endtask

  task automatic test_recapture();
    do_reset();
    ts_ready = 1'b0; phase = 3'd1;
    sb.push_back({2'd1, {22'd40, 3'd1}});
    sb.push_back({2'd0, {22'd50, 3'd1}});
    sb.push_back({2'd0, {22'd60, 3'd1}});
    gtin = 22'd40; trig = 4'b0010; tick();
    trig = '0; tick();
    gtin = 22'd50; trig = 4'b0001; tick();
    trig = '0; tick();
    total++;
    if (busy !== 4'b0001 || ts_src !== 2'd1) begin
      bad++; $display("FAIL recap_setup: got busy=%b src=%0d, expected 0001 1", busy, ts_src);
    end
    gtin = 22'd60; trig = 4'b0001; ts_ready = 1'b1;
    tick();
    total++;
    if (ts_data !== {22'd50, 3'd1} || ts_src !== 2'd0 || busy !== 4'b0001 || lost !== 16'd0) begin
      bad++; $display("FAIL recap_same_cycle: got data=%h src=%0d busy=%b lost=%0d, expected %h 0 0001 0",
                      ts_data, ts_src, busy, lost, {22'd50, 3'd1});
    end
    trig = '0; gtin = 22'd61;
    tick();
    total++;
    if (ts_data !== {22'd60, 3'd1} || ts_valid !== 1'b1 || busy !== 4'b0000) begin
      bad++; $display("FAIL recap_second: got data=%h valid=%b busy=%b, expected %h 1 0000", ts_data, ts_valid, busy, {22'd60, 3'd1});
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    ts_ready = 1'b0; gtin = 22'd300; phase = 3'd0;
    trig = 4'b1111; tick();
    trig = '0;      tick();
    trig = 4'b1111; tick();
    total++;
    if (lost !== 16'd3 || busy !== 4'b1111) begin
      bad++; $display("FAIL sat_fill: got lost=%0d busy=%b, expected 3 1111", lost, busy);
    end
    trig = '0; lost_clr = 1'b1; tick();
    lost_clr = 1'b0;
    total++;
    if (lost !== 16'd0) begin bad++; $display("FAIL sat_clr0: got %0d, expected 0", lost); end
    trig = 4'b1111; tick();
    total++;
    if (lost !== 16'd4) begin bad++; $display("FAIL sat_multi: got %0d, expected 4", lost); end
    trig = '0; tick();
    for (int p = 0; p < 16382; p++) begin
      trig = 4'b1111; tick();
      trig = '0;      tick();
    end
    total++;
    if (lost !== 16'hFFFC) begin bad++; $display("FAIL sat_near: got %h, expected fffc", lost); end
    trig = 4'b1111; tick();
    total++;
    if (lost !== 16'hFFFF) begin bad++; $display("FAIL sat_clamp: got %h, expected ffff", lost); end
    trig = '0; tick();
    trig = 4'b0010; tick();
    total++;
    if (lost !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h, expected ffff", lost); end
    trig = '0; tick();
    trig = 4'b0001; lost_clr = 1'b1; tick();
    total++;
    if (lost !== 16'd0) begin bad++; $display("FAIL sat_clr_prio: got %h, expected 0", lost); end
    lost_clr = 1'b0; trig = '0; tick();
    trig = 4'b0100; tick();
    total++;
    if (lost !== 16'd1) begin bad++; $display("FAIL sat_resume: got %0d, expected 1", lost); end
    total++;
    if (busy !== 4'b1111 || ts_valid !== 1'b1 || ts_src !== 2'd0) begin
      bad++; $display("FAIL sat_stalled: got busy=%b valid=%b src=%0d, expected 1111 1 0", busy, ts_valid, ts_src);
    end
    trig = '0;
  endtask

  initial begin
    reset = 1'b1; trig = '1; ts_ready = 1'b1; lost_clr = 1'b0; gtin = '0; phase = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_recapture();
    test_saturation();
    do_reset();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
